// File: rtl/puf_ram_sequencer_pkg.sv
// Shared encodings for the PUF RAM sequencer: FSM states, host command bytes
// and response bytes.
package puf_seq_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_INIT       = 4'd0;
  localparam state_t ST_IDLE       = 4'd1;
  localparam state_t ST_ARG        = 4'd2;
  localparam state_t ST_RD_ADDR    = 4'd3;
  localparam state_t ST_RD_WAIT    = 4'd4;
  localparam state_t ST_RD_LATCH   = 4'd5;
  localparam state_t ST_TX_SEND    = 4'd6;
  localparam state_t ST_TX_WAIT_LO = 4'd7;
  localparam state_t ST_TX_WAIT_HI = 4'd8;
  localparam state_t ST_NEXT       = 4'd9;
  localparam state_t ST_FILL       = 4'd10;
  localparam state_t ST_ACK        = 4'd11;

  localparam logic [7:0] CMD_DUMP  = 8'h53;
  localparam logic [7:0] CMD_RANGE = 8'h72;
  localparam logic [7:0] CMD_ZERO  = 8'h7A;
  localparam logic [7:0] RSP_ERR   = 8'h3F;
  localparam logic [7:0] RSP_ACK   = 8'h4B;

  localparam int PUF_BYTES = 16384;

  // Even byte addresses map to the low half of a word.
  function automatic logic [7:0] select_byte(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/puf_ram_sequencer_if.sv
// UART byte interface plus combined_ram port as seen by the sequencer.
interface puf_ram_sequencer_if #(parameter int RAM_AW = 13);
  logic              uart_rx_ready;
  logic [7:0]        uart_data_from_rx;
  logic              uart_tx_ready;
  logic              uart_tx_enable;
  logic [7:0]        uart_data_to_tx;
  logic [RAM_AW-1:0] raddr;
  logic [15:0]       rdata;
  logic              we;
  logic [RAM_AW-1:0] waddr;
  logic [15:0]       wdata;
  logic [15:0]       wmask;
  logic              busy;

  modport master (
    input  uart_rx_ready, uart_data_from_rx, uart_tx_ready, rdata,
    output uart_tx_enable, uart_data_to_tx, raddr, we, waddr, wdata, wmask, busy
  );

  modport slave (
    output uart_rx_ready, uart_data_from_rx, uart_tx_ready, rdata,
    input  uart_tx_enable, uart_data_to_tx, raddr, we, waddr, wdata, wmask, busy
  );
endinterface

// File: rtl/puf_tx_handshake.sv
// Sends one byte to the UART TX core: waits for idle, strobes enable, then
// follows ready low and back high before reporting done.
module puf_tx_handshake
  import puf_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       uart_tx_ready,
  output logic       uart_tx_enable,
  output logic [7:0] uart_data_to_tx,
  output logic       done
);

  state_t     hs_q, hs_d;
  logic [7:0] data_q, data_d;
  logic       en_q, en_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q   <= ST_IDLE;
      data_q <= 8'h00;
      en_q   <= 1'b0;
    end else begin
      hs_q   <= hs_d;
      data_q <= data_d;
      en_q   <= en_d;
    end
  end

  // The byte is captured once on start so it stays stable on the TX pins
  // until the core has come back to idle.
  always_comb begin
    hs_d   = hs_q;
    data_d = data_q;
    en_d   = 1'b0;
    case (hs_q)
      ST_IDLE: if (start) begin
        data_d = byte_in;
        hs_d   = ST_TX_SEND;
      end
      ST_TX_SEND: if (uart_tx_ready) begin
        en_d = 1'b1;
        hs_d = ST_TX_WAIT_LO;
      end
      ST_TX_WAIT_LO: if (!uart_tx_ready) hs_d = ST_TX_WAIT_HI;
      ST_TX_WAIT_HI: if (uart_tx_ready) hs_d = ST_IDLE;
      default: hs_d = ST_IDLE;
    endcase
  end

  always_comb begin
    uart_tx_enable  = en_q;
    uart_data_to_tx = data_q;
    done            = (hs_q == ST_TX_WAIT_HI) && uart_tx_ready;
  end

endmodule

// File: rtl/puf_ram_sequencer.sv
// Host command decoder that dumps, range-dumps or zero-fills the PUF SRAM
// and streams bytes back over UART.
module puf_ram_sequencer
  import puf_seq_pkg::*;
#(
  parameter int RAM_AW     = 13,
  parameter int BYTE_AW    = 14,
  parameter int INIT_DUMMY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  puf_ram_sequencer_if.master  bus
);

  state_t             state_q, state_d;
  logic [BYTE_AW-1:0] ptr_q, ptr_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [1:0]         argc_q, argc_d;
  logic [RAM_AW-1:0]  raddr_q, raddr_d;
  logic [RAM_AW-1:0]  waddr_q, waddr_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               ret_idle_q, ret_idle_d;
  logic               busy_q, busy_d;

  logic       hs_start, hs_done, hs_tx_enable;
  logic [7:0] hs_data;

  puf_tx_handshake u_tx (
    .clk             (clk),
    .rst             (rst),
    .start           (hs_start),
    .byte_in         (tx_byte_q),
    .uart_tx_ready   (bus.uart_tx_ready),
    .uart_tx_enable  (hs_tx_enable),
    .uart_data_to_tx (hs_data),
    .done            (hs_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= (INIT_DUMMY != 0) ? ST_INIT : ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      argc_q     <= '0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      tx_byte_q  <= '0;
      ret_idle_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      argc_q     <= argc_d;
      raddr_q    <= raddr_d;
      waddr_q    <= waddr_d;
      tx_byte_q  <= tx_byte_d;
      ret_idle_q <= ret_idle_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    argc_d     = argc_q;
    raddr_d    = raddr_q;
    waddr_d    = waddr_q;
    tx_byte_d  = tx_byte_q;
    ret_idle_d = ret_idle_q;
    case (state_q)
      ST_INIT: begin
        tx_byte_d  = 8'h00;
        ret_idle_d = 1'b1;
        state_d    = ST_TX_SEND;
      end
      ST_IDLE: if (bus.uart_rx_ready) begin
        case (bus.uart_data_from_rx)
          CMD_DUMP: begin
            ptr_d   = '0;
            cnt_d   = 16'(PUF_BYTES);
            state_d = ST_RD_ADDR;
          end
          CMD_RANGE: begin
            argc_d  = '0;
            state_d = ST_ARG;
          end
          CMD_ZERO: begin
            waddr_d = '0;
            state_d = ST_FILL;
          end
          default: begin
            tx_byte_d  = RSP_ERR;
            ret_idle_d = 1'b1;
            state_d    = ST_TX_SEND;
          end
        endcase
      end
      // Argument order: ptr_hi, ptr_lo, len_hi, len_lo; ptr_hi bits above
      // the byte address width fall away in the cast.
      ST_ARG: if (bus.uart_rx_ready) begin
        argc_d = argc_q + 2'd1;
        case (argc_q)
          2'd0: ptr_d = BYTE_AW'({bus.uart_data_from_rx, ptr_q[7:0]});
          2'd1: ptr_d[7:0] = bus.uart_data_from_rx;
          2'd2: cnt_d = {bus.uart_data_from_rx, cnt_q[7:0]};
          2'd3: begin
            cnt_d   = {cnt_q[15:8], bus.uart_data_from_rx};
            state_d = ({cnt_q[15:8], bus.uart_data_from_rx} == 16'd0) ? ST_IDLE : ST_RD_ADDR;
          end
        endcase
      end
      ST_RD_ADDR: begin
        raddr_d = ptr_q[BYTE_AW-1:1];
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: state_d = ST_RD_LATCH;
      ST_RD_LATCH: begin
        tx_byte_d  = select_byte(bus.rdata, ptr_q[0]);
        ret_idle_d = 1'b0;
        state_d    = ST_TX_SEND;
      end
      ST_TX_SEND: if (hs_done) state_d = ret_idle_q ? ST_IDLE : ST_NEXT;
      ST_NEXT: begin
        cnt_d   = cnt_q - 16'd1;
        ptr_d   = ptr_q + 1'b1;
        state_d = (cnt_q == 16'd1) ? ST_IDLE : ST_RD_ADDR;
      end
      ST_FILL: begin
        waddr_d = waddr_q + 1'b1;
        if (waddr_q == {RAM_AW{1'b1}}) state_d = ST_ACK;
      end
      ST_ACK: begin
        tx_byte_d  = RSP_ACK;
        ret_idle_d = 1'b1;
        state_d    = ST_TX_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_comb begin
    hs_start            = (state_q == ST_TX_SEND);
    bus.we              = (state_q == ST_FILL);
    bus.raddr           = raddr_q;
    bus.waddr           = waddr_q;
    bus.wdata           = '0;
    bus.wmask           = '0;
    bus.busy            = busy_q;
    bus.uart_tx_enable  = hs_tx_enable;
    bus.uart_data_to_tx = hs_data;
  end

endmodule

// File: tb/tb_puf_ram_sequencer.sv
// Scoreboard bench: directed host commands, a registered-read RAM model and a
// UART TX model; a monitor pops expected bytes whenever the DUT strobes TX.
module tb_puf_ram_sequencer;

  logic clk;
  logic rst_n;

  puf_ram_sequencer_if #(.RAM_AW(13)) bus ();

  puf_ram_sequencer #(.RAM_AW(13), .BYTE_AW(14), .INIT_DUMMY(1)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int tx_seen = 0;

  logic [7:0]  exp_q[$];
  logic [28:0] bk_q[$];
  logic [15:0] mem    [8192];
  logic [15:0] shadow [8192];

  logic        fill_armed = 1'b0;
  int          fill_cnt   = 0;
  logic [12:0] fill_addr  = '0;
  logic [7:0]  mon_exp;

  function automatic logic [15:0] pat(input int i);
    return 16'(i * 40503 + 12345);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // RAM model: registered read, one write port, plus a backdoor preload queue.
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = pat(i);
    bus.rdata = '0;
    forever begin
      @(posedge clk);
      bus.rdata <= mem[bus.raddr];
      if (bus.we) mem[bus.waddr] = bus.wdata;
      while (bk_q.size() > 0) begin
        logic [28:0] bk;
        bk = bk_q.pop_front();
        mem[bk[28:16]] = bk[15:0];
      end
    end
  end

  // UART TX core model: ready drops for two cycles after each enable.
  initial begin
    int hold;
    hold = 0;
    bus.uart_tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.uart_tx_ready = 1'b1;
        hold = 0;
      end else if (bus.uart_tx_enable) begin
        bus.uart_tx_ready = 1'b0;
        hold = 2;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) bus.uart_tx_ready = 1'b1;
      end
    end
  end

  // Monitor: scoreboard on TX strobes, address/data check on RAM writes.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.uart_tx_enable) begin
      tx_seen++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_byte: got %02h, expected no byte", bus.uart_data_to_tx);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.uart_data_to_tx !== mon_exp) begin
          n_fail++;
          $display("FAIL tx_byte #%0d: got %02h, expected %02h", tx_seen, bus.uart_data_to_tx, mon_exp);
        end else begin
          $display("[TB] tx #%0d byte %02h", tx_seen, bus.uart_data_to_tx);
        end
      end
    end
    if (rst_n && bus.we) begin
      if (!fill_armed) begin
        chk("stray_we", 32'(bus.waddr), 32'hFFFF_FFFF);
      end else begin
        chk("fill_word", {3'b0, bus.waddr, bus.wdata}, {3'b0, fill_addr, 16'h0000});
        fill_addr++;
        fill_cnt++;
      end
    end
  end

  task automatic bk_write(input int addr, input logic [15:0] data);
    bk_q.push_back({13'(addr), data});
    shadow[addr] = data;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    bus.uart_rx_ready     = 1'b1;
    bus.uart_data_from_rx = b;
    @(negedge clk);
    bus.uart_rx_ready     = 1'b0;
  endtask

  task automatic expect_bytes(input int ptr, input int len);
    for (int k = 0; k < len; k++) begin
      int b;
      logic [15:0] w;
      b = (ptr + k) % 16384;
      w = shadow[b >> 1];
      exp_q.push_back(b[0] ? w[15:8] : w[7:0]);
    end
  endtask

  task automatic send_range(input int ptr, input int len);
    send_rx(8'h72);
    send_rx(8'(ptr >> 8));
    send_rx(8'(ptr));
    send_rx(8'(len >> 8));
    send_rx(8'(len));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    i = 0;
    while (bus.busy !== 1'b0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_seen(input int target, input int budget);
    int i;
    i = 0;
    while (tx_seen < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("dump_progress", 32'(tx_seen >= target), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx_enable"}, 32'(bus.uart_tx_enable), 32'd0);
    chk({tag, "_we"},        32'(bus.we),             32'd0);
    chk({tag, "_busy"},      32'(bus.busy),           32'd0);
    chk({tag, "_tx_data"},   32'(bus.uart_data_to_tx),32'd0);
    chk({tag, "_raddr"},     32'(bus.raddr),          32'd0);
    chk({tag, "_waddr"},     32'(bus.waddr),          32'd0);
    chk({tag, "_wdata"},     32'(bus.wdata),          32'd0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    bus.uart_rx_ready     = 1'b0;
    bus.uart_data_from_rx = 8'h00;
    for (int i = 0; i < 8192; i++) shadow[i] = pat(i);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_wmask", 32'(bus.wmask), 32'd0);

    // Dummy flush byte after reset release.
    exp_q.push_back(8'h00);
    rst_n = 1'b1;
    wait_drain("init", 100);
    wait_idle("init", 100);

    // Ranged read across a word boundary.
    bk_write(0, 16'hBEEF);
    bk_write(1, 16'h1234);
    expect_bytes(0, 3);
    send_range(16'h0000, 3);
    wait_drain("range3", 200);
    wait_idle("range3", 100);

    // Pointer wrap 16383 -> 0; upper ptr_hi bits ignored.
    bk_write(8191, 16'hAA55);
    bk_write(0, 16'h00C3);
    expect_bytes(16'h3FFF, 2);
    send_range(16'hFFFF, 2);
    wait_drain("wrap", 200);
    wait_idle("wrap", 100);

    // Zero length: no output, straight back to idle.
    base = tx_seen;
    send_range(16'h0010, 0);
    repeat (40) @(negedge clk);
    chk("len0_no_tx", 32'(tx_seen - base), 32'd0);
    wait_idle("len0", 10);

    // Unknown command.
    exp_q.push_back(8'h3F);
    send_rx(8'h41);
    wait_drain("badcmd", 100);
    wait_idle("badcmd", 100);

    // Full dump, a stray 'r' mid-stream, then reset at byte 100.
    base = tx_seen;
    expect_bytes(0, 100);
    send_rx(8'h53);
    wait_seen(base + 20, 1000);
    send_rx(8'h72);
    wait_seen(base + 100, 2000);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    chk("midreset_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    exp_q.push_back(8'h00);
    rst_n = 1'b1;
    wait_drain("reinit", 100);
    wait_idle("reinit", 100);

    // Zero fill of all 8192 words, then 'K'.
    fill_cnt   = 0;
    fill_addr  = '0;
    fill_armed = 1'b1;
    exp_q.push_back(8'h4B);
    send_rx(8'h7A);
    wait_drain("fill", 10000);
    wait_idle("fill", 100);
    fill_armed = 1'b0;
    chk("fill_count", 32'(fill_cnt), 32'd8192);
    for (int i = 0; i < 8192; i++) shadow[i] = 16'h0000;

    // Reads after fill come back as zero, including the wrapped end.
    expect_bytes(0, 4);
    send_range(16'h0000, 4);
    wait_drain("post_fill_lo", 200);
    wait_idle("post_fill_lo", 100);
    expect_bytes(16'h3FFE, 2);
    send_range(16'h3FFE, 2);
    wait_drain("post_fill_hi", 200);
    wait_idle("post_fill_hi", 100);

    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
